// File: rtl/wm_pkg.sv
// Shared codes for the washing-machine controller and its front panel.
package wm_pkg;

  typedef enum logic [2:0] {
    MS_IDLE     = 3'd0,
    MS_FILLING  = 3'd1,
    MS_HEATING  = 3'd2,
    MS_WASHING  = 3'd3,
    MS_DRAINING = 3'd4
  } machine_state_e;

  typedef enum logic [1:0] {
    SEL_PLAIN     = 2'b00,
    SEL_HEAT      = 2'b01,
    SEL_DETERGENT = 2'b10,
    SEL_DET_HEAT  = 2'b11
  } selector_e;

  typedef enum logic [1:0] {
    P_READY,
    P_ARMED,
    P_RUNNING,
    P_DONE
  } panel_state_e;

  function automatic logic [3:0] sel_to_led(input logic [1:0] sel);
    sel_to_led = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/wm_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, and 1-cycle
// pulses on the debounced rising and falling edges.
module wm_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
      level_d = sync_q[1];
      cnt_d   = '0;
      rise_d  = sync_q[1];
      fall_d  = ~sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
endmodule

// File: rtl/wm_front_panel.sv
// Front-panel input stage: debounced buttons, program selection and start
// handshake with the controller. Optional child lock under WM_CHILD_LOCK_EN.
module wm_front_panel
  import wm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = 16,
  parameter int unsigned ARM_TIMEOUT      = 8,
  parameter int unsigned LOCK_HOLD_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BTN_SELECT,
  input  logic       BTN_START,
  input  logic [2:0] MACHINE_STATE,
  output logic [1:0] SELECTOR,
  output logic       START,
  output logic       BUSY,
  output logic       DONE,
  output logic [3:0] PROGRAM_LED,
  output logic       CHILD_LOCK
);
  localparam int unsigned ARM_W = $clog2(ARM_TIMEOUT + 1);

  logic sel_level, sel_rise, sel_fall;
  logic start_level, start_rise, start_fall;
  logic sel_evt, start_evt, machine_active;

  wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_select (
    .clk(clk), .rst(rst), .btn_raw(BTN_SELECT),
    .level(sel_level), .rise(sel_rise), .fall(sel_fall)
  );

  wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .rst(rst), .btn_raw(BTN_START),
    .level(start_level), .rise(start_rise), .fall(start_fall)
  );

  assign machine_active = (MACHINE_STATE != MS_IDLE);

`ifdef WM_CHILD_LOCK_EN
  localparam int unsigned HOLD_W = $clog2(LOCK_HOLD_CYCLES + 1);
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              lock_q, lock_d, long_hold;
  logic              unused_lock;

  // Select acts on release; a long hold toggles the lock instead.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (!sel_level)
      hold_cnt_d = '0;
    else if (hold_cnt_q != HOLD_W'(LOCK_HOLD_CYCLES))
      hold_cnt_d = hold_cnt_q + 1'b1;
    long_hold = (hold_cnt_q == HOLD_W'(LOCK_HOLD_CYCLES));
    lock_d    = lock_q ^ (sel_fall & long_hold);
    sel_evt   = sel_fall & ~long_hold & ~lock_q;
    start_evt = start_rise & ~lock_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      lock_q     <= lock_d;
    end
  end

  assign CHILD_LOCK  = lock_q;
  assign unused_lock = ^{sel_rise, start_level, start_fall};
`else
  logic unused_lock;
  assign sel_evt     = sel_rise;
  assign start_evt   = start_rise;
  assign CHILD_LOCK  = 1'b0;
  assign unused_lock = ^{sel_level, sel_fall, start_level, start_fall,
                         (LOCK_HOLD_CYCLES != 0)};
`endif

  panel_state_e     state_q, state_d;
  logic [1:0]       selector_q, selector_d;
  logic [3:0]       led_q, led_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d    = state_q;
    selector_d = selector_q;
    arm_cnt_d  = arm_cnt_q;
    done_d     = done_q;
    unique case (state_q)
      P_READY: begin
        // A controller already running (e.g. panel-only reset) is adopted.
        if (machine_active) begin
          state_d = P_RUNNING;
        end else if (start_evt) begin
          state_d   = P_ARMED;
          arm_cnt_d = '0;
        end else if (sel_evt) begin
          selector_d = selector_q + 2'd1;
        end
      end
      P_ARMED: begin
        if (machine_active)
          state_d = P_RUNNING;
        else if (arm_cnt_q == ARM_W'(ARM_TIMEOUT - 1))
          state_d = P_READY;
        else
          arm_cnt_d = arm_cnt_q + 1'b1;
      end
      P_RUNNING: begin
        if (!machine_active) begin
          state_d = P_DONE;
          done_d  = 1'b1;
        end
      end
      P_DONE: begin
        if (sel_evt || start_evt) begin
          state_d = P_READY;
          done_d  = 1'b0;
        end
      end
      default: state_d = P_READY;
    endcase
    start_d = (state_d == P_ARMED);
    busy_d  = (state_d == P_ARMED) || (state_d == P_RUNNING);
    led_d   = sel_to_led(selector_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= P_READY;
      selector_q <= SEL_DETERGENT;
      led_q      <= 4'b0100;
      arm_cnt_q  <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      selector_q <= selector_d;
      led_q      <= led_d;
      arm_cnt_q  <= arm_cnt_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign SELECTOR    = selector_q;
  assign PROGRAM_LED = led_q;
  assign START       = start_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
endmodule

// File: tb/tb_wm_front_panel.sv
// Self-checking bench for wm_front_panel with a behavioural controller and a
// program/done model kept at the level of whole button operations.
module tb_wm_front_panel;
  localparam int unsigned N  = 16;
  localparam int unsigned AT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_sel, btn_start;
  logic [2:0] ms;
  logic [1:0] SELECTOR;
  logic       START, BUSY, DONE, CHILD_LOCK;
  logic [3:0] PROGRAM_LED;

  always #5 clk = ~clk;

  wm_front_panel #(
    .DEBOUNCE_CYCLES(N), .ARM_TIMEOUT(AT), .LOCK_HOLD_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .BTN_SELECT(btn_sel), .BTN_START(btn_start),
    .MACHINE_STATE(ms), .SELECTOR(SELECTOR), .START(START), .BUSY(BUSY),
    .DONE(DONE), .PROGRAM_LED(PROGRAM_LED), .CHILD_LOCK(CHILD_LOCK)
  );

  int total = 0;
  int bad   = 0;
  int m_sel;
  bit m_done;
  bit ctrl_auto, ms_forced;
  logic [2:0] ms_force_val;
  int run_len, run_left, start_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock; the controller model reacts to START as a registered block would.
  task automatic step();
    logic s;
    s = START;
    @(posedge clk);
    #1;
    if (ms_forced) begin
      ms = ms_force_val;
    end else if (run_left > 0) begin
      run_left--;
      ms = (run_left == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    end else if (ctrl_auto && s === 1'b1) begin
      ms       = 3'd1;
      run_left = run_len;
    end
    if (START === 1'b1) start_cnt++;
  endtask

  task automatic set_btn(input int which, input logic v);
    if (which == 0) btn_sel = v;
    else            btn_start = v;
  endtask

  task automatic press(input int which, input int hold);
    set_btn(which, 1'b1);
    repeat (hold) step();
    set_btn(which, 1'b0);
  endtask

  task automatic glitches(input int which, input int n);
    for (int g = 0; g < n; g++) begin
      int len;
      len = $urandom_range(1, N - 1);
      set_btn(which, 1'b1);
      repeat (len) step();
      set_btn(which, 1'b0);
      repeat ($urandom_range(1, 6)) step();
    end
  endtask

  task automatic check_prog(input string tag);
    check({tag, "_sel"}, SELECTOR, m_sel);
    check({tag, "_led"}, PROGRAM_LED, 32'd1 << m_sel);
  endtask

  // op 0: select press, op 1: start with a responsive controller, op 2: start timeout
  task automatic do_op(input int op);
    bit was_done;
    int which, exp_starts;
    was_done  = m_done;
    which     = (op == 0) ? 0 : 1;
    ctrl_auto = (op == 1);
    run_len   = $urandom_range(2, 30);
    glitches(which, $urandom_range(0, 3));
    start_cnt = 0;
    press(which, $urandom_range(N + 1, 40));
    repeat (60) step();
    exp_starts = 0;
    if (was_done)     m_done = 1'b0;
    else if (op == 0) m_sel = (m_sel + 1) % 4;
    else if (op == 1) begin m_done = 1'b1; exp_starts = 2; end
    else              exp_starts = AT;
    check("op_start_cycles", start_cnt, exp_starts);
    check_prog("op");
    check("op_done", DONE, m_done);
    check("op_busy", BUSY, 0);
    ctrl_auto = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; btn_sel = 1'b0; btn_start = 1'b0; ms = 3'd0;
    ctrl_auto = 1'b0; ms_forced = 1'b0; ms_force_val = 3'd0;
    run_len = 0; run_left = 0; start_cnt = 0;
    step(); step();
    m_sel = 2; m_done = 1'b0;
    check_prog("reset");
    check("reset_start", START, 0);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    check("reset_lock", CHILD_LOCK, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 3; i++) begin
      press(0, 20);
      repeat (25) step();
      m_sel = (m_sel + 1) % 4;
      check_prog("clean_select");
    end

    repeat (6) begin
      set_btn(0, 1'b1); repeat (5) step();
      set_btn(0, 1'b0); repeat (5) step();
    end
    repeat (25) step();
    check_prog("glitch5");
    glitches(0, 8);
    repeat (25) step();
    check_prog("glitch_rand");

`ifndef WM_CHILD_LOCK_EN
    set_btn(0, 1'b1);
    repeat (19) step();
    check("edge18_sel", SELECTOR, m_sel);
    step();
    m_sel = (m_sel + 1) % 4;
    check("edge19_sel", SELECTOR, m_sel);
    set_btn(0, 1'b0);
    repeat (25) step();
`else
    press(0, 20);
    repeat (25) step();
    m_sel = (m_sel + 1) % 4;
    check_prog("release_select");
`endif

    ctrl_auto = 1'b1; run_len = 100; start_cnt = 0;
    set_btn(1, 1'b1);
    repeat (19) step();
    check("start_pre", START, 0);
    step();
    check("start_rise", START, 1);
    check("start_busy", BUSY, 1);
    step();
    check("start_hold", START, 1);
    step();
    check("start_fall", START, 0);
    check("run_busy", BUSY, 1);
    repeat (5) step();
    set_btn(1, 1'b0);
    press(0, 20);
    repeat (25) step();
    check_prog("run_frozen");
    check("run_busy_late", BUSY, 1);
    for (int i = 0; i < 300 && run_left > 0; i++) step();
    check("run_end_wait", run_left, 0);
    check("done_before", DONE, 0);
    step();
    check("done_rise", DONE, 1);
    check("done_busy", BUSY, 0);
    check("run_start_cycles", start_cnt, 2);
    ctrl_auto = 1'b0;
    press(0, 20);
    repeat (25) step();
    check("done_clear", DONE, 0);
    check_prog("done_consume");

    start_cnt = 0;
    press(1, 20);
    repeat (40) step();
    check("timeout_start_cycles", start_cnt, AT);
    check("timeout_busy", BUSY, 0);
    check("timeout_done", DONE, 0);
    press(0, 20);
    repeat (25) step();
    m_sel = (m_sel + 1) % 4;
    check_prog("after_timeout");

    set_btn(0, 1'b1); set_btn(1, 1'b1);
    repeat (20) step();
    check("both_start", START, 1);
    check_prog("both_armed");
    set_btn(0, 1'b0); set_btn(1, 1'b0);
    repeat (40) step();
`ifdef WM_CHILD_LOCK_EN
    m_sel = (m_sel + 1) % 4;
`endif
    check("both_busy", BUSY, 0);
    check_prog("both_after");

    ms_forced = 1'b1; ms_force_val = 3'd0;
    set_btn(1, 1'b1);
    repeat (20) step();
    check("prereset_start", START, 1);
    set_btn(1, 1'b0);
    ms = 3'd3; ms_force_val = 3'd3; rst = 1'b1;
    step();
    m_sel = 2;
    check("rst_run_start", START, 0);
    check("rst_run_busy", BUSY, 0);
    check_prog("rst_run");
    rst = 1'b0; start_cnt = 0;
    step();
    check("adopt_busy", BUSY, 1);
    repeat (10) step();
    check("adopt_start_cycles", start_cnt, 0);
    ms = 3'd0; ms_force_val = 3'd0;
    step();
    check("adopt_done", DONE, 1);
    ms_forced = 1'b0;
    m_done = 1'b1;

    for (int i = 0; i < 20; i++) do_op($urandom_range(0, 2));

`ifdef WM_CHILD_LOCK_EN
    if (m_done) do_op(0);
    press(0, 70);
    repeat (25) step();
    check("lock_on", CHILD_LOCK, 1);
    check_prog("lock_on");
    start_cnt = 0;
    press(1, 20);
    repeat (40) step();
    check("lock_start_cycles", start_cnt, 0);
    check("lock_busy", BUSY, 0);
    press(0, 70);
    repeat (25) step();
    check("lock_off", CHILD_LOCK, 0);
    check_prog("lock_off");
`else
    check("lock_tied", CHILD_LOCK, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wm_front_panel.md
# wm_front_panel

Front-panel input stage directly upstream of the washing-machine controller FSM. Debounces the two raw panel buttons, maintains the user-selected wash program, and drives the controller's `SELECTOR` and `START` inputs. Observes the controller's `CURRENT_STATE` so that the program is frozen while a cycle runs and completion is flagged to the user.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16: consecutive stable samples needed to accept a button level change (≥2).
- `ARM_TIMEOUT`, 8: cycles `START` is held waiting for the controller to leave IDLE.
- `LOCK_HOLD_CYCLES`, 64: select-button hold length that toggles child lock (only with `WM_CHILD_LOCK_EN`).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `BTN_SELECT` in 1: raw, asynchronous, bouncy program-select button, 1 = pressed.
- `BTN_START` in 1: raw, asynchronous, bouncy start button, 1 = pressed.
- `MACHINE_STATE` in 3: controller `CURRENT_STATE`; 0 = IDLE, 1..4 = active.
- `SELECTOR` out 2: program to controller. 00 plain, 01 heat, 10 detergent, 11 detergent+heat.
- `START` out 1: start request to controller.
- `BUSY` out 1: a cycle is armed or running.
- `DONE` out 1: a cycle has finished; cleared by the next accepted press.
- `PROGRAM_LED` out 4: one-hot copy of `SELECTOR`, bit n lit for code n.
- `CHILD_LOCK` out 1: lock active; constant 0 without `WM_CHILD_LOCK_EN`.

## Operation
- Each button path: 2-flop synchronizer, then debouncer. The debouncer has a counter that increments while the synced level differs from the debounced level and clears on agreement. It flips the debounced level when the count reaches `DEBOUNCE_CYCLES`.
- A press event is a 1-cycle pulse on the debounced rising edge. A release event is the falling edge.
- The panel FSM has four states:
  - **READY**:
    - Select event: `SELECTOR` increments mod 4 (11 wraps to 00).
    - Start event: go to ARMED, `SELECTOR` unchanged.
    - Select and start in the same cycle: start wins; the select event is dropped.
    - If `MACHINE_STATE` != 0 while in READY (e.g. after a panel-only reset): go to RUNNING without issuing `START`.
  - **ARMED**:
    - `START`=1, `BUSY`=1.
    - When `MACHINE_STATE` != 0: go to RUNNING.
    - After `ARM_TIMEOUT` cycles still at 0: go back to READY with `START`=0 and `DONE` unchanged.
  - **RUNNING**:
    - `BUSY`=1; `SELECTOR` frozen; all button events ignored.
    - When `MACHINE_STATE` returns to 0: go to DONE.
  - **DONE**:
    - `DONE`=1.
    - The first select or start event is consumed. It clears `DONE`, returns to READY, and is not otherwise acted on.
- Out-of-range `MACHINE_STATE` (5–7) is treated as active.
- Reset values:
  - FSM state: READY.
  - `SELECTOR`=10, `PROGRAM_LED`=0100.
  - `START`, `BUSY`, `DONE`, `CHILD_LOCK`: 0.
  - Debounced levels and all counters: 0.
- Reset mid-operation takes effect on the next edge regardless of FSM state. Afterwards the READY adoption rule applies.

## Timing
- Clean press: raw level first sampled at edge 0; debounced level changes at edge `DEBOUNCE_CYCLES`+2; register outputs (`SELECTOR`, `START`, FSM state) update at edge `DEBOUNCE_CYCLES`+3.
- A bounce shorter than `DEBOUNCE_CYCLES` cycles produces no event.
- `START` rises one edge after the start event. It falls on the edge after `MACHINE_STATE` is first seen non-zero. With the controller in IDLE this gives `START` high for exactly 2 cycles.
- `DONE` rises one edge after `MACHINE_STATE` is first seen at 0 in RUNNING.
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- `WM_CHILD_LOCK_EN` defined:
  - Select acts on the release event instead of the press.
  - If the debounced hold lasted fewer than `LOCK_HOLD_CYCLES` cycles, the release acts as a normal select event.
  - If the hold lasted `LOCK_HOLD_CYCLES` or more, the release toggles `CHILD_LOCK` instead (hold counter saturates at that value).
  - While `CHILD_LOCK`=1, all select and start actions are ignored in every state, and `DONE` is held.
- `WM_CHILD_LOCK_EN` undefined: select acts on the press event, no hold counter exists, `CHILD_LOCK` is tied to 0.

## Structure
- Shared package `wm_pkg`:
  - controller state codes (IDLE=0, FILLING=1, HEATING=2, WASHING=3, DRAINING=4);
  - selector codes;
  - panel FSM encoding (READY, ARMED, RUNNING, DONE).
- Sub-module `wm_debounce`: synchronizer, counter and edge pulses, parameterized by `DEBOUNCE_CYCLES`; instantiated once per button.

## Test plan
- Reset, then 3 clean select presses → `SELECTOR` goes 10→11→00→01; `PROGRAM_LED` goes 1000→0001→0010.
- `BTN_SELECT` glitches of 5 cycles (`DEBOUNCE_CYCLES`=16) → no `SELECTOR` change. A 20-cycle press → exactly one increment, at edge 19.
- Start press with a modelled controller that leaves IDLE 1 cycle after `START` → `START` high 2 cycles, `BUSY`=1. Select presses during RUNNING leave `SELECTOR` unchanged. `MACHINE_STATE`→0 gives `DONE`=1; the next select press clears `DONE` with no increment.
- Start press with `MACHINE_STATE` held at 0 → `START` held 8 cycles, then READY with `BUSY`=0.
- Select and start debounced in the same cycle → ARMED, `SELECTOR` unchanged. Assert `rst` while `MACHINE_STATE`=3 → READY, then RUNNING the next cycle, `START` never asserted.
- With `WM_CHILD_LOCK_EN`: hold select 70 cycles → `CHILD_LOCK`=1, `SELECTOR` unchanged. Start press then ignored. Hold select 70 cycles again → `CHILD_LOCK`=0.
